// File: rtl/lookahead_carry_unit.sv
// ---------------------------------------------------------------------------
// lookahead_carry_unit
// Registered carry-lookahead unit for one WIDTH-bit group of a CLA adder.
// Every carry is built as a flat sum-of-products of g/p/c_in, so no
// carry term depends on another carry term. Group P/G are also produced for a
// higher-level lookahead stage. The result is registered with one cycle of
// latency and a valid strobe.
//
// Optional feature macro: LCU_COUNT_EN
//   When this macro is defined, the module adds the output cout_cnt[15:0]. It
//   is a saturating count of accepted transactions whose carry-out is 1.
// ---------------------------------------------------------------------------
module lookahead_carry_unit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] g,
    input  logic             c_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] c,
    output logic             c_out,
    output logic             P,
    output logic             G
`ifdef LCU_COUNT_EN
    ,
    output logic [15:0]      cout_cnt
`endif
);

    // Bit mask with bits lo..hi-1 set. It is only called with elaboration
    // constants, so each product term collapses to a fixed AND of p bits.
    function automatic logic [WIDTH-1:0] span_mask(input int lo, input int hi);
        logic [WIDTH-1:0] m;
        m = '0;
        for (int b = 0; b < WIDTH; b++) begin
            if ((b >= lo) && (b < hi)) begin
                m[b] = 1'b1;
            end
        end
        return m;
    endfunction

    // gen_part[i]  : carry into bit i when c_in is 0 (sum of generate terms)
    // prop_part[i] : AND of p[0..i-1], the path from c_in to bit i
    // k_comb[i]    : full carry into bit i; k_comb[WIDTH] is the carry-out
    logic [WIDTH:1] gen_part;
    logic [WIDTH:1] prop_part;
    logic [WIDTH:0] k_comb;

    assign k_comb[0] = c_in;

    // Flattened lookahead. For carry i, term j is g[j] ANDed with every
    // propagate strictly above j and below i. Bits outside that span are
    // forced to 1 by the inverted mask, so they do not affect the AND
    // reduction.
    genvar gi, gj;
    generate
        for (gi = 1; gi <= WIDTH; gi++) begin : g_carry
            logic [gi-1:0] terms;
            for (gj = 0; gj < gi; gj++) begin : g_term
                assign terms[gj] = g[gj] & (&(p | ~span_mask(gj + 1, gi)));
            end
            assign gen_part[gi]  = |terms;
            assign prop_part[gi] = &(p | ~span_mask(0, gi));
            assign k_comb[gi]    = gen_part[gi] | (prop_part[gi] & c_in);
        end
    endgenerate

    // Group terms come directly from the widest span. This means
    // c_out == G | (P & c_in) holds by construction.
    logic grp_p_next;
    logic grp_g_next;

    assign grp_p_next = prop_part[WIDTH];
    assign grp_g_next = gen_part[WIDTH];

    logic [WIDTH-1:0] c_reg;
    logic             c_out_reg;
    logic             grp_p_reg;
    logic             grp_g_reg;
    logic             out_valid_reg;

    // Result registers: capture on in_valid, hold otherwise, and clear on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_reg         <= '0;
            c_out_reg     <= 1'b0;
            grp_p_reg     <= 1'b0;
            grp_g_reg     <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                c_reg     <= k_comb[WIDTH-1:0];
                c_out_reg <= k_comb[WIDTH];
                grp_p_reg <= grp_p_next;
                grp_g_reg <= grp_g_next;
            end
        end
    end

    assign c         = c_reg;
    assign c_out     = c_out_reg;
    assign P         = grp_p_reg;
    assign G         = grp_g_reg;
    assign out_valid = out_valid_reg;

`ifdef LCU_COUNT_EN
    logic [15:0] cout_cnt_reg;

    // Saturating count of accepted results whose carry-out is 1. It updates
    // on the same edge that loads c_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            cout_cnt_reg <= '0;
        end else if (in_valid && k_comb[WIDTH] && (cout_cnt_reg != 16'hFFFF)) begin
            cout_cnt_reg <= cout_cnt_reg + 16'd1;
        end
    end

    assign cout_cnt = cout_cnt_reg;
`endif

endmodule

// File: tb/tb_lookahead_carry_unit.sv
// ---------------------------------------------------------------------------
// tb_lookahead_carry_unit
// Scoreboard bench for lookahead_carry_unit with WIDTH = 4. The driver
// applies inputs on the falling edge and pushes the ripple-model result into
// a queue. The monitor samples 1 ns after each rising edge. It pops and
// compares a result when one is due. Otherwise it checks that the outputs
// hold their values, or are zero after a reset.
// ---------------------------------------------------------------------------
module tb_lookahead_carry_unit;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] c;
        logic         c_out;
        logic         P;
        logic         G;
        logic         c_in;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] p = '0;
    logic [W-1:0] g = '0;
    logic         c_in = 1'b0;
    logic         out_valid;
    logic [W-1:0] c;
    logic         c_out;
    logic         P;
    logic         G;
`ifdef LCU_COUNT_EN
    logic [15:0]  cout_cnt;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    exp_t        sb[$];
    exp_t        held = '0;
    logic [15:0] cnt_exp = '0;

    lookahead_carry_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .p         (p),
        .g         (g),
        .c_in      (c_in),
        .out_valid (out_valid),
        .c         (c),
        .c_out     (c_out),
        .P         (P),
        .G         (G)
`ifdef LCU_COUNT_EN
        ,
        .cout_cnt  (cout_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: plain ripple recurrence
    function automatic exp_t model(input logic [W-1:0] pv, input logic [W-1:0] gv, input logic cv);
        exp_t e;
        logic k;
        logic k0;
        k  = cv;
        k0 = 1'b0;
        for (int i = 0; i < W; i++) begin
            e.c[i] = k;
            k  = gv[i] | (pv[i] & k);
            k0 = gv[i] | (pv[i] & k0);
        end
        e.c_out = k;
        e.G     = k0;
        e.P     = &pv;
        e.c_in  = cv;
        return e;
    endfunction

    // Drive one cycle of stimulus on the falling edge; queue expected result if accepted
    task automatic apply(input logic [W-1:0] pv, input logic [W-1:0] gv, input logic cv, input logic vld);
        exp_t e;
        @(negedge clk);
        p = pv;
        g = gv;
        c_in = cv;
        in_valid = vld;
        if (vld && !rst) begin
            e = model(pv, gv, cv);
            sb.push_back(e);
            if (e.c_out && cnt_exp != 16'hFFFF) cnt_exp = cnt_exp + 16'd1;
            $display("[TB] txn p=%b g=%b c_in=%b -> c=%b c_out=%b P=%b G=%b",
                     pv, gv, cv, e.c, e.c_out, e.P, e.G);
        end
    endtask

    // Monitor: pop the result when it is due, otherwise expect held/reset values
    initial begin
        exp_t cur;
        logic due;
        forever begin
            @(posedge clk);
            #1;
            due = (sb.size() != 0);
            check_value("out_valid", {31'd0, out_valid}, {31'd0, due});
            if (rst) held = '0;
            if (due) begin
                cur  = sb.pop_front();
                held = cur;
                check_value("ident", {31'd0, G | (P & cur.c_in)}, {31'd0, cur.c_out});
            end
            check_value("c",     {28'd0, c},    {28'd0, held.c});
            check_value("c_out", {31'd0, c_out}, {31'd0, held.c_out});
            check_value("P",     {31'd0, P},    {31'd0, held.P});
            check_value("G",     {31'd0, G},    {31'd0, held.G});
`ifdef LCU_COUNT_EN
            check_value("cout_cnt", {16'd0, cout_cnt}, {16'd0, cnt_exp});
`endif
        end
    end

    initial begin
        // Initial reset (monitor checks all-zero outputs on these edges)
        rst = 1'b1;
        cnt_exp = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed vectors. Vector 1 from the recurrence: k = 0,0,1,1,1 -> c=1100
        apply(4'b1111, 4'b0110, 1'b0, 1'b1);
        apply(4'b1101, 4'b0010, 1'b0, 1'b1);
        apply(4'b1100, 4'b1001, 1'b0, 1'b1);
        apply(4'b1111, 4'b0000, 1'b1, 1'b1);
        // Drop in_valid with different inputs: outputs must hold
        apply(4'b0000, 4'b1111, 1'b0, 1'b0);
        apply(4'b0101, 4'b1010, 1'b1, 1'b0);

        // Reset with in_valid high: transaction dropped, outputs cleared
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        p = 4'b1111;
        g = 4'b1111;
        c_in = 1'b1;
        cnt_exp = '0;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        apply(4'b1111, 4'b0110, 1'b0, 1'b1);
        apply(4'b0000, 4'b0000, 1'b0, 1'b0);

        // Random back-to-back traffic with occasional idle cycles
        for (int n = 0; n < 10000; n++) begin
            apply(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0));
        end
        apply(4'b0000, 4'b0000, 1'b0, 1'b0);
        apply(4'b0000, 4'b0000, 1'b0, 1'b0);

        check_value("sb_drain", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
